uart_apb: RTL and testbench

- Single-channel UART with an 8-bit APB3 slave register interface: one transmitter, one receiver, programmable baud generator.
- Sits on a peripheral APB bus and exposes TX/RX pins plus status flags as discrete outputs for interrupt or GPIO monitoring.
- Single-entry holding registers on TX and RX; no FIFOs.

---
 rtl/uart_apb.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_apb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb.sv
// rtl/uart_apb.sv - APB3 UART with single-entry TX/RX holding registers and programmable baud
module uart_apb #(
  parameter int FIXEDMODE         = 0,
  parameter int BAUD_VALUE        = 1,
  parameter int PRG_BIT8          = 1,
  parameter int PRG_PARITY        = 0,
  parameter int BAUD_VAL_FRCTN_EN = 0,
  parameter int BAUD_VAL_FRCTN    = 0
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [4:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       TXRDY,
  output logic       RXRDY,
  output logic       PARITY_ERR,
  output logic       FRAMING_ERR,
  output logic       OVERFLOW,
  input  logic       RX,
  output logic       TX
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [12:0] BAUD_P  = 13'(BAUD_VALUE);
  localparam logic [7:0]  CTRL1_P = BAUD_P[7:0];
  localparam logic [7:0]  CTRL2_P = {BAUD_P[12:8], (PRG_PARITY == 2), (PRG_PARITY != 0), (PRG_BIT8 != 0)};
  localparam logic [2:0]  CTRL3_P = 3'(BAUD_VAL_FRCTN);

  logic [7:0]  ctrl1, ctrl2;
  logic [2:0]  ctrl3;
  logic        wr_en, rd_rx;
  logic [13:0] baud_cnt, baud_lim;
  logic [2:0]  frac_cnt;
  logic        tick;

  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign rd_rx   = PSEL & PENABLE & ~PWRITE & (PADDR == 5'h04);
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  // Control registers; in fixed mode they keep their parameter-derived reset values
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl1 <= CTRL1_P;
      ctrl2 <= CTRL2_P;
      ctrl3 <= CTRL3_P;
    end else if (wr_en && FIXEDMODE == 0) begin
      case (PADDR)
        5'h08:   ctrl1 <= PWDATA;
        5'h0C:   ctrl2 <= PWDATA;
        5'h14:   ctrl3 <= PWDATA[2:0];
        default: ;
      endcase
    end
  end

  // Oversample tick generator; the first F ticks of every group of 8 are stretched by one clock
  assign baud_lim = {1'b0, ctrl2[7:3], ctrl1} +
                    ((BAUD_VAL_FRCTN_EN != 0 && frac_cnt < ctrl3) ? 14'd1 : 14'd0);
  assign tick = (baud_cnt >= baud_lim);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      baud_cnt <= '0;
      frac_cnt <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
      frac_cnt <= frac_cnt + 3'd1;
    end else begin
      baud_cnt <= baud_cnt + 14'd1;
    end
  end

  // ---------------- transmitter ----------------
  state_t     tx_state, tx_next;
  logic [3:0] tx_cnt;
  logic [2:0] tx_bits;
  logic [7:0] tx_hold, tx_sh;
  logic       tx_rdy, tx_par, tx_d, tx_load, tx_bit_done, tx_last;

  assign tx_bit_done = tick && (tx_cnt == 4'd15);
  assign tx_last     = (tx_bits == (ctrl2[0] ? 3'd7 : 3'd6));
  assign tx_load     = !tx_rdy && (tx_state == S_IDLE || (tx_state == S_STOP && tx_bit_done));
  assign TXRDY       = tx_rdy;

  // TX state register
  always_ff @(posedge PCLK) begin
    if (PRESET) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  // TX next state; a queued byte goes straight from STOP into START
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:   if (!tx_rdy) tx_next = S_START;
      S_START:  if (tx_bit_done) tx_next = S_DATA;
      S_DATA:   if (tx_bit_done && tx_last) tx_next = ctrl2[1] ? S_PARITY : S_STOP;
      S_PARITY: if (tx_bit_done) tx_next = S_STOP;
      S_STOP:   if (tx_bit_done) tx_next = tx_rdy ? S_IDLE : S_START;
      default:  tx_next = S_IDLE;
    endcase
  end

  // TX line level for the current state
  always_comb begin
    tx_d = 1'b1;
    case (tx_state)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = tx_sh[0];
      S_PARITY: tx_d = tx_par;
      default:  tx_d = 1'b1;
    endcase
  end

  // TX holding register, shifter, bit counters and registered TX pin
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      TX      <= 1'b1;
      tx_rdy  <= 1'b1;
      tx_hold <= '0;
      tx_sh   <= '0;
      tx_par  <= 1'b0;
      tx_cnt  <= '0;
      tx_bits <= '0;
    end else begin
      TX <= tx_d;
      if (tx_load) begin
        tx_rdy  <= 1'b1;
        tx_sh   <= tx_hold;
        tx_par  <= (^(ctrl2[0] ? tx_hold : {1'b0, tx_hold[6:0]})) ^ ctrl2[2];
        tx_cnt  <= '0;
        tx_bits <= '0;
      end else begin
        if (wr_en && PADDR == 5'h00 && tx_rdy) begin
          tx_rdy  <= 1'b0;
          tx_hold <= PWDATA;
        end
        if (tick) tx_cnt <= tx_cnt + 4'd1;
        if (tx_bit_done && tx_state == S_DATA) begin
          tx_sh   <= {1'b0, tx_sh[7:1]};
          tx_bits <= tx_bits + 3'd1;
        end
      end
    end
  end

  // ---------------- receiver ----------------
  state_t     rx_state, rx_next;
  logic       rx_s1, rx_s2, rx_prev;
  logic [3:0] rx_cnt;
  logic [2:0] rx_bits;
  logic [7:0] rx_sh, rx_data, rx_buf;
  logic       rx_parbit, rx_sample, rx_last, rx_perr;
  logic       rx_shift, rx_cap_par, rx_done;
  logic       rxrdy_q, perr_q, ferr_q, ovf_q;

  assign rx_sample = tick && ((rx_state == S_START) ? (rx_cnt == 4'd7) : (rx_cnt == 4'd15));
  assign rx_last   = (rx_bits == (ctrl2[0] ? 3'd7 : 3'd6));
  assign rx_data   = ctrl2[0] ? rx_sh : {1'b0, rx_sh[7:1]};
  assign rx_perr   = ctrl2[1] && (rx_parbit != ((^rx_data) ^ ctrl2[2]));

  // RX state register
  always_ff @(posedge PCLK) begin
    if (PRESET) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  // RX next state; only a falling edge arms a frame, so a line stuck low yields one frame
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_prev && !rx_s2) rx_next = S_START;
      S_START:  if (rx_sample) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (rx_sample && rx_last) rx_next = ctrl2[1] ? S_PARITY : S_STOP;
      S_PARITY: if (rx_sample) rx_next = S_STOP;
      S_STOP:   if (rx_sample) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
  end

  // RX per-state sample strobes
  always_comb begin
    rx_shift   = 1'b0;
    rx_cap_par = 1'b0;
    rx_done    = 1'b0;
    case (rx_state)
      S_DATA:   rx_shift   = rx_sample;
      S_PARITY: rx_cap_par = rx_sample;
      S_STOP:   rx_done    = rx_sample;
      default:  ;
    endcase
  end

  // RX synchroniser, tick counter restarted on every state change, data shifter
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_cnt    <= '0;
      rx_bits   <= '0;
      rx_sh     <= '0;
      rx_parbit <= 1'b0;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_next != rx_state) rx_cnt <= '0;
      else if (tick)           rx_cnt <= rx_cnt + 4'd1;
      if (rx_state == S_START) rx_bits <= '0;
      if (rx_shift) begin
        rx_sh   <= {rx_s2, rx_sh[7:1]};
        rx_bits <= rx_bits + 3'd1;
      end
      if (rx_cap_par) rx_parbit <= rx_s2;
    end
  end

  // RX buffer and flags; a frame completing alongside an RXDATA read wins over the clear
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_buf  <= '0;
      rxrdy_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (rd_rx) begin
        rxrdy_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end
      if (rx_done) begin
        rx_buf  <= rx_data;
        rxrdy_q <= 1'b1;
        if (rx_perr)           perr_q <= 1'b1;
        if (!rx_s2)            ferr_q <= 1'b1;
        if (rxrdy_q && !rd_rx) ovf_q  <= 1'b1;
      end
    end
  end

  assign RXRDY       = rxrdy_q;
  assign PARITY_ERR  = perr_q;
  assign FRAMING_ERR = ferr_q;
  assign OVERFLOW    = ovf_q;

  // Read mux, driven only while selected
  always_comb begin
    PRDATA = 8'h00;
    if (PSEL) begin
      case (PADDR)
        5'h04:   PRDATA = rx_buf;
        5'h08:   PRDATA = ctrl1;
        5'h0C:   PRDATA = ctrl2;
        5'h10:   PRDATA = {3'b000, ferr_q, ovf_q, perr_q, rxrdy_q, tx_rdy};
        5'h14:   PRDATA = {5'b00000, ctrl3};
        default: PRDATA = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_apb.sv
// tb/tb_uart_apb.sv - two-UART loopback bench with scoreboard and frame-level reference model
module tb_uart_apb;
  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       psel_a = 1'b0, penable_a = 1'b0, pwrite_a = 1'b0;
  logic [4:0] paddr_a = '0;
  logic [7:0] pwdata_a = '0;
  logic [7:0] prdata_a;
  logic       pready_a, pslverr_a, txrdy_a, rxrdy_a, perr_a, ferr_a, ovf_a, tx_a;
  logic       psel_b = 1'b0, penable_b = 1'b0, pwrite_b = 1'b0;
  logic [4:0] paddr_b = '0;
  logic [7:0] pwdata_b = '0;
  logic [7:0] prdata_b;
  logic       pready_b, pslverr_b, txrdy_b, rxrdy_b, perr_b, ferr_b, ovf_b, tx_b;
  logic       rx_force_low = 1'b0;
  logic       rx_b;
  logic       mon_hold = 1'b0;

  assign rx_b = rx_force_low ? 1'b0 : tx_a;

  uart_apb u_a (
    .PCLK(clk), .PRESET(rst), .PSEL(psel_a), .PENABLE(penable_a), .PWRITE(pwrite_a),
    .PADDR(paddr_a), .PWDATA(pwdata_a), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a),
    .TXRDY(txrdy_a), .RXRDY(rxrdy_a), .PARITY_ERR(perr_a), .FRAMING_ERR(ferr_a),
    .OVERFLOW(ovf_a), .RX(1'b1), .TX(tx_a));

  uart_apb u_b (
    .PCLK(clk), .PRESET(rst), .PSEL(psel_b), .PENABLE(penable_b), .PWRITE(pwrite_b),
    .PADDR(paddr_b), .PWDATA(pwdata_b), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b),
    .TXRDY(txrdy_b), .RXRDY(rxrdy_b), .PARITY_ERR(perr_b), .FRAMING_ERR(ferr_b),
    .OVERFLOW(ovf_b), .RX(rx_b), .TX(tx_b));

  int          checks = 0;
  int          errors = 0;
  int          frames_seen = 0;
  exp_t        exp_q[$];
  logic [12:0] cfg_q[$];
  logic [7:0]  a_ctrl2 = 8'h01;
  logic [7:0]  b_ctrl2 = 8'h01;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Serialise the byte with the sender's format, then deserialise it with the receiver's
  function automatic exp_t model(input logic [7:0] d, input logic [7:0] txc,
                                 input logic [7:0] rxc, input logic ovf);
    bit         seq[$];
    exp_t       r;
    int         idx;
    logic [7:0] dm;
    dm = txc[0] ? d : (d & 8'h7F);
    seq.push_back(1'b0);
    for (int i = 0; i < (txc[0] ? 8 : 7); i++) seq.push_back(dm[i]);
    if (txc[1]) seq.push_back((^dm) ^ txc[2]);
    repeat (5) seq.push_back(1'b1);
    r.data = 8'h00;
    for (int i = 0; i < (rxc[0] ? 8 : 7); i++) r.data[i] = seq[1 + i];
    idx = rxc[0] ? 9 : 8;
    r.perr = 1'b0;
    if (rxc[1]) begin
      r.perr = (seq[idx] != ((^r.data) ^ rxc[2]));
      idx++;
    end
    r.ferr = !seq[idx];
    r.ovf  = ovf;
    return r;
  endfunction

  task automatic apb_a_wr(input logic [4:0] a, input logic [7:0] d);
    psel_a = 1'b1; penable_a = 1'b0; pwrite_a = 1'b1; paddr_a = a; pwdata_a = d;
    @(negedge clk); penable_a = 1'b1;
    @(negedge clk); psel_a = 1'b0; penable_a = 1'b0; pwrite_a = 1'b0;
  endtask

  task automatic apb_a_rd(input logic [4:0] a, output logic [7:0] d);
    psel_a = 1'b1; penable_a = 1'b0; pwrite_a = 1'b0; paddr_a = a;
    @(negedge clk); penable_a = 1'b1; #1 d = prdata_a;
    @(negedge clk); psel_a = 1'b0; penable_a = 1'b0;
  endtask

  task automatic apb_b_wr(input logic [4:0] a, input logic [7:0] d);
    psel_b = 1'b1; penable_b = 1'b0; pwrite_b = 1'b1; paddr_b = a; pwdata_b = d;
    @(negedge clk); penable_b = 1'b1;
    @(negedge clk); psel_b = 1'b0; penable_b = 1'b0; pwrite_b = 1'b0;
  endtask

  task automatic apb_b_rd(input logic [4:0] a, output logic [7:0] d);
    psel_b = 1'b1; penable_b = 1'b0; pwrite_b = 1'b0; paddr_b = a;
    @(negedge clk); penable_b = 1'b1; #1 d = prdata_b;
    @(negedge clk); psel_b = 1'b0; penable_b = 1'b0;
  endtask

  task automatic wait_txrdy_a();
    int n = 0;
    while (!txrdy_a && n < 2000) begin @(negedge clk); n++; end
    check_int("txrdy_wait_cycles", n, 0, 1999);
  endtask

  task automatic send_a(input logic [7:0] d, input bit push, input logic ovf);
    wait_txrdy_a();
    if (push) exp_q.push_back(model(d, a_ctrl2, b_ctrl2, ovf));
    apb_a_wr(5'h00, d);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin @(negedge clk); n++; end
    check_int("drain_cycles", n, 0, 3999);
    repeat (64) @(negedge clk);
  endtask

  task automatic set_ctrl2(input logic [7:0] v);
    logic [7:0] rd;
    int n = 0;
    apb_a_wr(5'h0C, v);
    a_ctrl2 = v;
    apb_a_rd(5'h0C, rd);
    check8("a_ctrl2_readback", rd, v);
    cfg_q.push_back({5'h0C, v});
    while (cfg_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check_int("cfg_b_cycles", n, 0, 99);
    repeat (4) @(negedge clk);
    b_ctrl2 = v;
  endtask

  // Monitor: owns B's bus, consumes each received frame against the scoreboard
  initial begin : monitor
    exp_t        e;
    logic [7:0]  d;
    logic [12:0] c;
    forever begin
      @(negedge clk);
      if (!rst && !mon_hold && rxrdy_b) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          apb_b_rd(5'h04, d);
          $display("FAIL unexpected_frame: got rxdata 0x%02h expected no frame", d);
        end else begin
          e = exp_q.pop_front();
          check1("parity_err_pin", perr_b, e.perr);
          check1("framing_err_pin", ferr_b, e.ferr);
          check1("overflow_pin", ovf_b, e.ovf);
          apb_b_rd(5'h10, d);
          check8("b_status", d, {3'b000, e.ferr, e.ovf, e.perr, 2'b11});
          apb_b_rd(5'h04, d);
          check8("b_rxdata", d, e.data);
          check1("rxrdy_cleared", rxrdy_b, 1'b0);
          check8("flags_cleared", {5'b0, perr_b, ferr_b, ovf_b}, 8'h00);
        end
        frames_seen++;
      end else if (!rst && cfg_q.size() != 0) begin
        c = cfg_q.pop_front();
        apb_b_wr(c[12:8], c[7:0]);
      end
    end
  end

  initial begin : watchdog
    #(600_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] rd;
    int         n, f0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check1("a_tx_idle", tx_a, 1'b1);
    check1("b_tx_idle", tx_b, 1'b1);
    check1("a_txrdy_reset", txrdy_a, 1'b1);
    check1("b_rxrdy_reset", rxrdy_b, 1'b0);
    check8("a_flags_reset", {4'b0, rxrdy_a, perr_a, ferr_a, ovf_a}, 8'h00);
    check8("bus_ties", {4'b0, pready_a, pslverr_a, pready_b, pslverr_b}, 8'b1010);
    check1("b_txrdy_reset", txrdy_b, 1'b1);
    paddr_a = 5'h08;
    #1 check8("prdata_unselected", prdata_a, 8'h00);
    apb_a_rd(5'h10, rd); check8("a_status_reset", rd, 8'h01);
    apb_a_rd(5'h08, rd); check8("a_ctrl1_reset", rd, 8'h01);
    apb_a_rd(5'h0C, rd); check8("a_ctrl2_reset", rd, 8'h01);
    apb_a_rd(5'h18, rd); check8("a_unmapped", rd, 8'h00);

    // first frame latency, 8N1 at baud=1
    send_a(8'h55, 1'b1, 1'b0);
    n = 0;
    while (!rxrdy_b && n < 1000) begin @(negedge clk); n++; end
    check_int("rx_latency", n, 290, 330);
    drain();

    for (int i = 0; i < 6; i++) send_a(8'($urandom), 1'b1, 1'b0);
    drain();

    // even parity in both
    set_ctrl2(8'h03);
    send_a(8'hA7, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_a(8'($urandom), 1'b1, 1'b0);
    drain();

    // receiver expects odd while sender sends even
    cfg_q.push_back({5'h0C, 8'h07});
    n = 0;
    while (cfg_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    b_ctrl2 = 8'h07;
    send_a(8'hA7, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) send_a(8'($urandom), 1'b1, 1'b0);
    drain();

    // 7-bit, no parity
    set_ctrl2(8'h00);
    for (int i = 0; i < 3; i++) send_a(8'($urandom), 1'b1, 1'b0);
    drain();

    // overrun: second byte lands on an unread first byte
    set_ctrl2(8'h01);
    mon_hold = 1'b1;
    send_a(8'h11, 1'b0, 1'b0);
    send_a(8'h22, 1'b1, 1'b1);
    repeat (800) @(negedge clk);
    check1("overflow_held", ovf_b, 1'b1);
    mon_hold = 1'b0;
    drain();

    // line held low for two frame times
    f0 = frames_seen;
    exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, ovf: 1'b0});
    rx_force_low = 1'b1;
    repeat (640) @(negedge clk);
    check_int("held_low_frames", frames_seen - f0, 1, 1);
    rx_force_low = 1'b0;
    repeat (400) @(negedge clk);
    check_int("after_release_frames", frames_seen - f0, 1, 1);
    send_a(8'h3C, 1'b1, 1'b0);
    drain();
    check_int("rearm_frames", frames_seen - f0, 2, 2);

    // third write while the holding register is full is dropped
    f0 = frames_seen;
    send_a(8'h81, 1'b1, 1'b0);
    send_a(8'h7E, 1'b1, 1'b0);
    check1("txrdy_full", txrdy_a, 1'b0);
    apb_a_wr(5'h00, 8'hEE);
    drain();
    repeat (400) @(negedge clk);
    check_int("two_frames_only", frames_seen - f0, 2, 2);
    check_int("scoreboard_empty", exp_q.size(), 0, 0);
    check1("a_rxrdy_never", rxrdy_a, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
